// File: rtl/pc_fetch_ctrl.sv
// Fetch-side PC owner: one-outstanding instruction-memory reads, sequential/redirect PC update,
// and IF/ID delivery with a single-entry buffer that absorbs decode stalls.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    localparam int unsigned    XLEN = 32;
    localparam logic [XLEN-1:0] NOP  = 32'h0000_0013;
    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    typedef enum logic [1:0] {START, REQ, WAIT, HOLD} state_t;

    state_t          state_q, state_n;
    logic [XLEN-1:0] pc_q, pc_n;
    logic [XLEN-1:0] pc_req_q, pc_req_n;
    logic [XLEN-1:0] buf_q, buf_n;
    logic            kill_q, kill_n;
    logic            req_q;
    logic            deliver_c;
    logic [XLEN-1:0] deliver_instr_c;
    logic [XLEN-1:0] target_c;
    logic            unused_c;

    // Redirect targets are always word aligned; the low bits are dropped.
    assign target_c    = {PCTargetE[31:2], 2'b00};
    assign unused_c    = ^PCTargetE[1:0];
    assign imem_req_o  = req_q;
    assign imem_addr_o = pc_q;

    // Next-state, PC and delivery selection.
    always_comb begin
        state_n         = state_q;
        pc_n            = pc_q;
        pc_req_n        = pc_req_q;
        buf_n           = buf_q;
        kill_n          = kill_q;
        deliver_c       = 1'b0;
        deliver_instr_c = buf_q;
        unique case (state_q)
            START: begin
                state_n = REQ;
                if (PCSrcE) pc_n = target_c;
            end
            REQ: begin
                if (imem_gnt_i) begin
                    pc_req_n = pc_q;
                    state_n  = WAIT;
                    if (PCSrcE) begin
                        pc_n   = target_c;
                        kill_n = 1'b1;
                    end else begin
                        pc_n = pc_q + STEP;
                    end
                end else if (PCSrcE) begin
                    pc_n = target_c;
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    state_n = REQ;
                    kill_n  = 1'b0;
                    if (PCSrcE) begin
                        pc_n = target_c;
                    end else if (!kill_q) begin
                        if (StallF) begin
                            buf_n   = imem_rdata_i;
                            state_n = HOLD;
                        end else begin
                            deliver_c       = 1'b1;
                            deliver_instr_c = imem_rdata_i;
                        end
                    end
                end else if (PCSrcE) begin
                    pc_n   = target_c;
                    kill_n = 1'b1;
                end
            end
            HOLD: begin
                if (PCSrcE) begin
                    pc_n    = target_c;
                    state_n = REQ;
                end else if (!StallF) begin
                    deliver_c       = 1'b1;
                    deliver_instr_c = buf_q;
                    state_n         = REQ;
                end
            end
            default: state_n = START;
        endcase
    end

    // State, request and IF/ID registers; a flush beats a stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= START;
            pc_q     <= RESET_PC;
            pc_req_q <= RESET_PC;
            buf_q    <= NOP;
            kill_q   <= 1'b0;
            req_q    <= 1'b0;
            InstrD   <= NOP;
            PCD      <= RESET_PC;
            PCPlus4D <= RESET_PC + STEP;
            ValidD   <= 1'b0;
        end else begin
            state_q  <= state_n;
            pc_q     <= pc_n;
            pc_req_q <= pc_req_n;
            buf_q    <= buf_n;
            kill_q   <= kill_n;
            req_q    <= (state_n == REQ);
            if (PCSrcE) begin
                ValidD <= 1'b0;
            end else if (!StallF) begin
                ValidD <= deliver_c;
                if (deliver_c) begin
                    InstrD   <= deliver_instr_c;
                    PCD      <= pc_req_q;
                    PCPlus4D <= pc_req_q + STEP;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: scoreboarded fetches, stall buffering, redirects,
// mid-transaction reset, and PC wrap on a second instance with RESET_PC near the top.
module tb_pc_fetch_ctrl;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallF, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
    logic [31:0] imem_addr_o, imem_rdata_i;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    logic        rst_w;
    logic        req_w, gnt_w;
    logic        rvalid_w = 1'b0;
    logic [31:0] addr_w;
    logic [31:0] rdata_w = 32'h0;
    logic [31:0] instr_w, pcd_w, plus4_w;
    logic        valid_w;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    pc_fetch_ctrl #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) u_dut (
        .clk(clk), .rst(rst), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    pc_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) u_wrap (
        .clk(clk), .rst(rst_w), .StallF(1'b0), .PCSrcE(1'b0), .PCTargetE(32'h0),
        .imem_req_o(req_w), .imem_addr_o(addr_w), .imem_gnt_i(gnt_w),
        .imem_rvalid_i(rvalid_w), .imem_rdata_i(rdata_w),
        .InstrD(instr_w), .PCD(pcd_w), .PCPlus4D(plus4_w), .ValidD(valid_w)
    );

    // Zero-wait memory for the wrap instance: grant immediately, data one cycle later.
    assign gnt_w = req_w;
    always @(posedge clk) begin
        rvalid_w <= req_w && gnt_w;
        rdata_w  <= ~addr_w;
    end

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   32'(imem_req_o), 32'd0);
        chk({tag, "_addr"},  imem_addr_o,     32'h0);
        chk({tag, "_instr"}, InstrD,          32'h0000_0013);
        chk({tag, "_pcd"},   PCD,             32'h0);
        chk({tag, "_plus4"}, PCPlus4D,        32'h4);
        chk({tag, "_valid"}, 32'(ValidD),     32'd0);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!imem_req_o && n < 16) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, 32'(imem_req_o), 32'd1);
    endtask

    task automatic expect_d(input string tag);
        exp_t e;
        chk({tag, "_valid"}, 32'(ValidD), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_instr"}, InstrD,   e.instr);
            chk({tag, "_pcd"},   PCD,      e.pc);
            chk({tag, "_plus4"}, PCPlus4D, e.pc + 32'd4);
        end
    endtask

    task automatic fetch(input string tag, input logic [31:0] a);
        wait_req(tag);
        chk({tag, "_addr"}, imem_addr_o, a);
        imem_gnt_i = 1'b1;
        sb.push_back('{pc: a, instr: instr_of(a)});
        tick();
        imem_gnt_i = 1'b0;
        chk({tag, "_req_wait"}, 32'(imem_req_o), 32'd0);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = instr_of(a);
        tick();
        imem_rvalid_i = 1'b0;
        expect_d(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] wexp_pc[3];
        logic [31:0] wexp_p4[3];
        int          got;

        rst = 1'b0; rst_w = 1'b0;
        StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
        repeat (3) tick();
        chk_reset("reset");

        // Sequential fetches straight out of reset
        rst = 1'b1;
        chk("start_req", 32'(imem_req_o), 32'd0);
        fetch("seq0", 32'h0);
        fetch("seq4", 32'h4);
        fetch("seq8", 32'h8);

        // Decode stall while data returns: buffered, no new request until released
        wait_req("stall");
        chk("stall_addr", imem_addr_o, 32'hC);
        imem_gnt_i = 1'b1;
        sb.push_back('{pc: 32'hC, instr: 32'hDEAD_BEEF});
        tick();
        imem_gnt_i    = 1'b0;
        StallF        = 1'b1;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("hold_req",   32'(imem_req_o), 32'd0);
            chk("hold_valid", 32'(ValidD),     32'd0);
            tick();
        end
        chk("hold_req_last", 32'(imem_req_o), 32'd0);
        StallF = 1'b0;
        tick();
        expect_d("hold_rel");
        chk("hold_resume_req", 32'(imem_req_o), 32'd1);

        // Redirect while waiting: the in-flight response must be dropped
        wait_req("rdw");
        chk("rdw_addr", imem_addr_o, 32'h10);
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        PCSrcE = 1'b1; PCTargetE = 32'h100;
        tick();
        PCSrcE = 1'b0;
        chk("rdw_valid0", 32'(ValidD),     32'd0);
        chk("rdw_req0",   32'(imem_req_o), 32'd0);
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_0010;
        tick();
        imem_rvalid_i = 1'b0;
        chk("rdw_valid1", 32'(ValidD),     32'd0);
        chk("rdw_req1",   32'(imem_req_o), 32'd1);
        chk("rdw_addr1",  imem_addr_o,     32'h100);
        fetch("tgt100", 32'h100);

        // Redirect in the same cycle as a grant, misaligned target
        wait_req("rdg");
        chk("rdg_addr", imem_addr_o, 32'h104);
        imem_gnt_i = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h203;
        tick();
        imem_gnt_i = 1'b0; PCSrcE = 1'b0;
        chk("rdg_valid0", 32'(ValidD),     32'd0);
        chk("rdg_req0",   32'(imem_req_o), 32'd0);
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_0104;
        tick();
        imem_rvalid_i = 1'b0;
        chk("rdg_valid1", 32'(ValidD),     32'd0);
        chk("rdg_addr1",  imem_addr_o,     32'h200);
        fetch("tgt200", 32'h200);

        // Reset during WAIT, then a late response after release
        wait_req("mrst");
        chk("mrst_addr", imem_addr_o, 32'h204);
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        rst = 1'b0;
        #1;
        chk_reset("mrst");
        tick();
        rst = 1'b1;
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_0204;
        tick();
        imem_rvalid_i = 1'b0;
        chk("mrst_valid", 32'(ValidD),     32'd0);
        chk("mrst_req",   32'(imem_req_o), 32'd1);
        chk("mrst_addr0", imem_addr_o,     32'h0);
        tick();
        chk("mrst_valid2", 32'(ValidD), 32'd0);
        fetch("mrst_f0", 32'h0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // Address wrap on the second instance
        wexp_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        wexp_p4 = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        got = 0;
        rst_w = 1'b1;
        for (int i = 0; i < 40 && got < 3; i++) begin
            tick();
            if (valid_w) begin
                chk("wrap_pcd",   pcd_w,   wexp_pc[got]);
                chk("wrap_plus4", plus4_w, wexp_p4[got]);
                chk("wrap_instr", instr_w, ~wexp_pc[got]);
                got++;
            end
        end
        chk("wrap_count", 32'(got), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
